// File: rtl/arb_pkg.sv
// Shared types and helpers for the arbiter family.
//   arb_wb_state_t : FSM encoding for the weighted burst arbiter.
//   idx_width()    : index width for an N-entry vector that never collapses to 0 bits.
package arb_pkg;

  typedef enum logic [0:0] {IDLE, BURST} arb_wb_state_t;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pointer_select.sv
// Rotating priority encoder. It scans req_i upward starting at ptr_i+1
// (mod N) and returns the first set bit.
//   req_i   : request vector
//   ptr_i   : last winner; the scan starts just above it
//   win_o   : index of the selected requester (0 when none)
//   valid_o : at least one request was set
module rr_pointer_select
  import arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int IDXW = idx_width(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [IDXW-1:0] win_o,
  output logic            valid_o
);

  always_comb begin
    int idx;
    win_o   = '0;
    valid_o = 1'b0;
    idx     = 0;
    // i runs 1..N so the pointer's own slot is considered last.
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr_i) + i) % N;
      if (!valid_o && req_i[idx]) begin
        valid_o = 1'b1;
        win_o   = IDXW'(idx);
      end
    end
  end

endmodule

// File: rtl/arbiter_weighted_burst.sv
// Weighted round-robin burst scheduler. It shares one downstream FIFO among
// CLIENTS source FIFOs. A winner keeps ownership for up to its weight in beats.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_req        : per-client "source FIFO not empty"
//   i_weight     : per-client max beats per tenure, 0 disables the client
//   i_block_arb  : suspends selection and beats
//   i_dst_full   : downstream FIFO full
//   o_gnt        : one-hot beat strobe (source read enable / dest write enable)
//   o_gnt_id     : current or last owner (registered)
//   o_last       : qualifies o_gnt; final beat of the tenure
//   o_busy       : tenure in progress (registered)
//
// Handshake: o_gnt[k] is a single-cycle transfer strobe. It is asserted only
// in a cycle where i_req[k] is high (source has data) and i_dst_full is low
// (destination has room). Both flags are sampled in that same cycle, so the
// strobe never reads an empty FIFO and never writes a full one.
module arbiter_weighted_burst
  import arb_pkg::*;
#(
  parameter int CLIENTS      = 4,
  parameter int WEIGHT_WIDTH = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [CLIENTS-1:0]              i_req,
  input  logic [CLIENTS*WEIGHT_WIDTH-1:0] i_weight,
  input  logic                            i_block_arb,
  input  logic                            i_dst_full,
  output logic [CLIENTS-1:0]              o_gnt,
  output logic [idx_width(CLIENTS)-1:0]   o_gnt_id,
  output logic                            o_last,
  output logic                            o_busy
);

  localparam int IDXW = idx_width(CLIENTS);
  localparam int WW   = WEIGHT_WIDTH;

  arb_wb_state_t   state_q, state_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic [WW-1:0]   wgt_q, wgt_d;
  logic [WW-1:0]   cnt_q, cnt_d;

  logic [CLIENTS-1:0] elig;
  logic [IDXW-1:0]    sel_idx;
  logic               sel_valid;
  logic [WW-1:0]      sel_wgt;
  logic               beat;

  // A zero-weight client is treated as disabled, not as a zero-length tenure.
  always_comb begin
    elig = '0;
    for (int k = 0; k < CLIENTS; k++) begin
      elig[k] = i_req[k] & (i_weight[k*WW +: WW] != '0);
    end
  end

  rr_pointer_select #(
    .N    (CLIENTS),
    .IDXW (IDXW)
  ) u_sel (
    .req_i   (elig),
    .ptr_i   (owner_q),
    .win_o   (sel_idx),
    .valid_o (sel_valid)
  );

  always_comb begin
    sel_wgt = '0;
    for (int k = 0; k < CLIENTS; k++) begin
      if (IDXW'(k) == sel_idx) sel_wgt = i_weight[k*WW +: WW];
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wgt_d   = wgt_q;
    cnt_d   = cnt_q;
    beat    = 1'b0;
    o_gnt   = '0;
    o_last  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_valid && !i_block_arb) begin
          owner_d = sel_idx;
          wgt_d   = sel_wgt;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        // Gating with i_rst ensures no strobe is issued while a tenure is being aborted.
        beat   = i_req[owner_q] & ~i_dst_full & ~i_block_arb & ~i_rst;
        o_last = beat & (cnt_q == wgt_q - WW'(1));
        if (!i_req[owner_q]) begin
          state_d = IDLE;        // source drained; give up the rest of the tenure
        end else if (beat) begin
          cnt_d = cnt_q + WW'(1);
          if (o_last) state_d = IDLE;
        end
        o_gnt[owner_q] = beat;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      owner_q <= IDXW'(CLIENTS - 1);  // client 0 wins first after reset
      wgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wgt_q   <= wgt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_gnt_id = owner_q;
  assign o_busy   = (state_q == BURST);

endmodule

// File: tb/tb_arbiter_weighted_burst.sv
// Directed bench for arbiter_weighted_burst (CLIENTS=4, WEIGHT_WIDTH=4).
module tb_arbiter_weighted_burst;

  localparam int CLIENTS = 4;
  localparam int WW      = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [CLIENTS-1:0]   req;
  logic [CLIENTS*WW-1:0] weight;
  logic                 blk;
  logic                 full;
  logic [CLIENTS-1:0]   gnt;
  logic [1:0]           gid;
  logic                 last;
  logic                 busy;

  arbiter_weighted_burst #(
    .CLIENTS      (CLIENTS),
    .WEIGHT_WIDTH (WW)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_weight    (weight),
    .i_block_arb (blk),
    .i_dst_full  (full),
    .o_gnt       (gnt),
    .o_gnt_id    (gid),
    .o_last      (last),
    .o_busy      (busy)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  int cyc_no   = 0;
  int gcount[CLIENTS];

  logic [3:0] exp_gnt_q[$];
  logic       exp_last_q[$];
  logic       exp_busy_q[$];
  logic [1:0] exp_id_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic l, input logic b, input logic [1:0] id);
    exp_gnt_q.push_back(g);
    exp_last_q.push_back(l);
    exp_busy_q.push_back(b);
    exp_id_q.push_back(id);
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are changed 1 time unit after posedge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input int n);
    logic [3:0] eg;
    logic       el, eb;
    logic [1:0] ei;
    for (int i = 0; i < n; i++) begin
      #1;
      eg = exp_gnt_q.pop_front();
      el = exp_last_q.pop_front();
      eb = exp_busy_q.pop_front();
      ei = exp_id_q.pop_front();
      chk($sformatf("%s[%0d].gnt", tag, i),  32'(gnt),  32'(eg));
      chk($sformatf("%s[%0d].last", tag, i), 32'(last), 32'(el));
      chk($sformatf("%s[%0d].busy", tag, i), 32'(busy), 32'(eb));
      chk($sformatf("%s[%0d].id", tag, i),   32'(gid),  32'(ei));
      for (int k = 0; k < CLIENTS; k++) gcount[k] += int'(gnt[k]);
      cyc_no++;
      tick();
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    blk  = 1'b0;
    full = 1'b0;
    tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; req = '0; weight = '0; blk = 1'b0; full = 1'b0;
    for (int k = 0; k < CLIENTS; k++) gcount[k] = 0;
    tick();
    tick();

    // Reset state, still in reset.
    push(4'b0000, 0, 0, 2'd3);
    run("reset", 1);

    // All request, weight 2 each: two-beat tenures with a bubble, in order 0..3.
    rst = 1'b0; req = 4'b1111; weight = 16'h2222;
    push(4'b0000, 0, 0, 2'd3);
    push(4'b0001, 0, 1, 2'd0); push(4'b0001, 1, 1, 2'd0); push(4'b0000, 0, 0, 2'd0);
    push(4'b0010, 0, 1, 2'd1); push(4'b0010, 1, 1, 2'd1); push(4'b0000, 0, 0, 2'd1);
    push(4'b0100, 0, 1, 2'd2); push(4'b0100, 1, 1, 2'd2); push(4'b0000, 0, 0, 2'd2);
    push(4'b1000, 0, 1, 2'd3); push(4'b1000, 1, 1, 2'd3); push(4'b0000, 0, 0, 2'd3);
    push(4'b0001, 0, 1, 2'd0); push(4'b0001, 1, 1, 2'd0);
    run("rr_w2", 15);

    // Weights {3:0,2:3,1:1,0:4}; client 3 disabled.
    do_reset();
    rst = 1'b0; req = 4'b1111; weight = 16'h0314;
    for (int k = 0; k < CLIENTS; k++) gcount[k] = 0;
    push(4'b0000, 0, 0, 2'd3);
    push(4'b0001, 0, 1, 2'd0); push(4'b0001, 0, 1, 2'd0);
    push(4'b0001, 0, 1, 2'd0); push(4'b0001, 1, 1, 2'd0);
    push(4'b0000, 0, 0, 2'd0);
    push(4'b0010, 1, 1, 2'd1);
    push(4'b0000, 0, 0, 2'd1);
    push(4'b0100, 0, 1, 2'd2); push(4'b0100, 0, 1, 2'd2); push(4'b0100, 1, 1, 2'd2);
    push(4'b0000, 0, 0, 2'd2);
    run("wmix", 12);
    chk("wmix.beats_c0", 32'(gcount[0]), 32'd4);
    chk("wmix.beats_c1", 32'(gcount[1]), 32'd1);
    chk("wmix.beats_c2", 32'(gcount[2]), 32'd3);
    chk("wmix.beats_c3", 32'(gcount[3]), 32'd0);

    // Client 0 alone, weight 8, source drains after 3 beats.
    do_reset();
    rst = 1'b0; req = 4'b0001; weight = 16'h0008;
    push(4'b0000, 0, 0, 2'd3);
    push(4'b0001, 0, 1, 2'd0); push(4'b0001, 0, 1, 2'd0); push(4'b0001, 0, 1, 2'd0);
    run("drain", 4);
    req = 4'b0000;
    push(4'b0000, 0, 1, 2'd0); push(4'b0000, 0, 0, 2'd0);
    run("drain_end", 2);
    req = 4'b0001;
    push(4'b0000, 0, 0, 2'd0); push(4'b0001, 0, 1, 2'd0);
    run("drain_resel", 2);

    // Weight 4, destination full for 5 cycles after beat 2.
    do_reset();
    rst = 1'b0; req = 4'b0001; weight = 16'h0004;
    push(4'b0000, 0, 0, 2'd3);
    push(4'b0001, 0, 1, 2'd0); push(4'b0001, 0, 1, 2'd0);
    run("full_pre", 3);
    full = 1'b1;
    for (int i = 0; i < 5; i++) push(4'b0000, 0, 1, 2'd0);
    run("full_stall", 5);
    full = 1'b0;
    push(4'b0001, 0, 1, 2'd0); push(4'b0001, 1, 1, 2'd0); push(4'b0000, 0, 0, 2'd0);
    run("full_post", 3);

    // Block pulses: in IDLE (prevents selection) and mid-tenure (holds count).
    do_reset();
    rst = 1'b0; req = 4'b0001; weight = 16'h0003; blk = 1'b1;
    push(4'b0000, 0, 0, 2'd3); push(4'b0000, 0, 0, 2'd3);
    run("blk_idle", 2);
    blk = 1'b0;
    push(4'b0000, 0, 0, 2'd3); push(4'b0001, 0, 1, 2'd0);
    run("blk_start", 2);
    blk = 1'b1;
    push(4'b0000, 0, 1, 2'd0); push(4'b0000, 0, 1, 2'd0);
    run("blk_burst", 2);
    blk = 1'b0;
    push(4'b0001, 0, 1, 2'd0); push(4'b0001, 1, 1, 2'd0); push(4'b0000, 0, 0, 2'd0);
    run("blk_resume", 3);

    // Reset during beat 2 of a weight-5 tenure owned by client 2.
    do_reset();
    rst = 1'b0; req = 4'b0100; weight = 16'h5555;
    push(4'b0000, 0, 0, 2'd3); push(4'b0100, 0, 1, 2'd2);
    run("abort_pre", 2);
    rst = 1'b1;
    push(4'b0000, 0, 1, 2'd2);
    run("abort_rst", 1);
    rst = 1'b0; req = 4'b1111;
    push(4'b0000, 0, 0, 2'd3); push(4'b0001, 0, 1, 2'd0);
    run("abort_post", 2);

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
